// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths and FSM encodings for the fetch stage
package inst_fetch_pkg;

    localparam int DEF_PC_WIDTH     = 14;
    localparam int DEF_INST_WIDTH   = 18;
    localparam int DEF_OPCODE_WIDTH = 4;
    localparam int PERF_CNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        S_RESET   = 2'b00,
        S_FETCH   = 2'b01,
        S_DISCARD = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {inst, pc} skid register with load/drain/clear
module fetch_skid_buf
    import inst_fetch_pkg::*;
#(
    parameter int INST_WIDTH = DEF_INST_WIDTH,
    parameter int PC_WIDTH   = DEF_PC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  drain,
    input  logic                  clear,
    input  logic [INST_WIDTH-1:0] load_inst,
    input  logic [PC_WIDTH-1:0]   load_pc,
    output logic                  full,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            inst <= '0;
            pc   <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            inst <= load_inst;
            pc   <= load_pc;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch stage and IF/ID register; FETCH_PERF_CNT_EN adds perf counters
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                 PC_WIDTH     = DEF_PC_WIDTH,
    parameter int                 INST_WIDTH   = DEF_INST_WIDTH,
    parameter int                 OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_stall,
    input  logic                    i_redirect,
    input  logic [PC_WIDTH-1:0]     i_redirect_pc,
    output logic                    o_imem_req,
    output logic [PC_WIDTH-1:0]     o_imem_addr,
    input  logic                    i_imem_ready,
    input  logic [INST_WIDTH-1:0]   i_imem_rdata,
    output logic                    o_valid,
    output logic [INST_WIDTH-1:0]   o_inst,
    output logic [PC_WIDTH-1:0]     o_pc,
    output logic [OPCODE_WIDTH-1:0] o_opcode
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] o_perf_fetched,
    output logic [PERF_CNT_WIDTH-1:0] o_perf_bubbles
`endif
);

    fetch_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH-1:0]   hold_addr_q;
    logic                  accept, to_ifid, to_skid, drain;
    logic                  skid_full;
    logic [INST_WIDTH-1:0] skid_inst;
    logic [PC_WIDTH-1:0]   skid_pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_RESET;
            pc_q        <= RESET_PC;
            hold_addr_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == S_FETCH && state_d == S_DISCARD)
                hold_addr_q <= pc_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        o_imem_req  = 1'b0;
        o_imem_addr = pc_q;
        case (state_q)
            S_RESET:   state_d = S_FETCH;
            S_FETCH:   o_imem_req = !skid_full;
            S_DISCARD: begin
                // the abandoned request must still complete on its original address
                o_imem_req  = 1'b1;
                o_imem_addr = hold_addr_q;
                if (i_imem_ready)
                    state_d = S_FETCH;
            end
            default:   state_d = S_RESET;
        endcase

        accept = (state_q == S_FETCH) && o_imem_req && i_imem_ready && !i_redirect;
        if (accept)
            pc_d = pc_q + PC_WIDTH'(1);

        if (i_redirect) begin
            pc_d = i_redirect_pc;
            if (state_q == S_FETCH && o_imem_req && !i_imem_ready)
                state_d = S_DISCARD;
        end

        // an accept only happens with the skid empty, so drain and accept never overlap
        to_ifid = accept && (!o_valid || !i_stall);
        to_skid = accept && !to_ifid;
        drain   = skid_full && !i_stall && !i_redirect;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_inst  <= '0;
            o_pc    <= '0;
        end else if (i_redirect) begin
            o_valid <= 1'b0;
        end else if (to_ifid) begin
            o_valid <= 1'b1;
            o_inst  <= i_imem_rdata;
            o_pc    <= pc_q;
        end else if (drain) begin
            o_valid <= 1'b1;
            o_inst  <= skid_inst;
            o_pc    <= skid_pc;
        end else if (!i_stall) begin
            o_valid <= 1'b0;
        end
    end

    assign o_opcode = o_inst[INST_WIDTH-1 -: OPCODE_WIDTH];

    fetch_skid_buf #(
        .INST_WIDTH(INST_WIDTH),
        .PC_WIDTH  (PC_WIDTH)
    ) u_skid (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (to_skid),
        .drain    (drain),
        .clear    (i_redirect),
        .load_inst(i_imem_rdata),
        .load_pc  (pc_q),
        .full     (skid_full),
        .inst     (skid_inst),
        .pc       (skid_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] perf_fetched_q, perf_bubbles_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if ((to_ifid || drain) && perf_fetched_q != {PERF_CNT_WIDTH{1'b1}})
                perf_fetched_q <= perf_fetched_q + PERF_CNT_WIDTH'(1);
            if (!o_valid && !i_stall && perf_bubbles_q != {PERF_CNT_WIDTH{1'b1}})
                perf_bubbles_q <= perf_bubbles_q + PERF_CNT_WIDTH'(1);
        end
    end

    assign o_perf_fetched = perf_fetched_q;
    assign o_perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_stall;
    logic        i_redirect;
    logic [13:0] i_redirect_pc;
    logic        o_imem_req;
    logic [13:0] o_imem_addr;
    logic        i_imem_ready;
    logic [17:0] i_imem_rdata;
    logic        o_valid;
    logic [17:0] o_inst;
    logic [13:0] o_pc;
    logic [3:0]  o_opcode;

    int n_pass  = 0;
    int n_total = 0;
    int wcnt    = 0;
    int wait_states = 0;

    inst_fetch dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_stall      (i_stall),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ready (i_imem_ready),
        .i_imem_rdata (i_imem_rdata),
        .o_valid      (o_valid),
        .o_inst       (o_inst),
        .o_pc         (o_pc),
        .o_opcode     (o_opcode)
    );

    always #5 i_clk = ~i_clk;

    // memory word: opcode field = low address nibble ^ 5, low 14 bits = address
    function automatic logic [17:0] mem_word(input logic [13:0] a);
        mem_word = {a[3:0] ^ 4'h5, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive_mem();
        i_imem_ready = o_imem_req && (wcnt >= wait_states);
        i_imem_rdata = mem_word(o_imem_addr);
    endtask

    task automatic tick();
        logic busy;
        busy = o_imem_req && !i_imem_ready;
        @(posedge i_clk);
        #1;
        wcnt = busy ? wcnt + 1 : 0;
        drive_mem();
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_stall = 1'b0;
        i_redirect = 1'b0;
        i_redirect_pc = '0;
        i_imem_ready = 1'b0;
        i_imem_rdata = '0;
        tick();
        tick();
        check("rst_req",    32'(o_imem_req),  32'd0);
        check("rst_addr",   32'(o_imem_addr), 32'd0);
        check("rst_valid",  32'(o_valid),     32'd0);
        check("rst_inst",   32'(o_inst),      32'd0);
        check("rst_pc",     32'(o_pc),        32'd0);
        check("rst_opcode", 32'(o_opcode),    32'd0);

        // zero-wait streaming
        i_rst_n = 1'b1;
        tick();
        check("t1_req",   32'(o_imem_req),  32'd1);
        check("t1_addr",  32'(o_imem_addr), 32'd0);
        check("t1_valid", 32'(o_valid),     32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("stream_valid", 32'(o_valid), 32'd1);
            check("stream_pc",    32'(o_pc),    32'(k));
            check("stream_inst",  32'(o_inst),  32'(mem_word(14'(k))));
        end
        check("stream_opcode_pc5", 32'(o_opcode), 32'h0);

        // stall with PC 5 in IF/ID while the fetch of 6 completes
        i_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stall_req",   32'(o_imem_req), 32'd0);
            check("stall_pc",    32'(o_pc),       32'd5);
            check("stall_valid", 32'(o_valid),    32'd1);
        end
        i_stall = 1'b0;
        tick();
        check("unstall_pc6",    32'(o_pc),     32'd6);
        check("unstall_opcode", 32'(o_opcode), 32'h3);
        tick();
        check("unstall_pc7",    32'(o_pc),     32'd7);
        check("unstall_valid7", 32'(o_valid),  32'd1);

        // two wait states: address held 3 cycles, one instruction per 3 cycles
        wait_states = 2;
        drive_mem();
        check("ws_addr_c0", 32'(o_imem_addr), 32'd8);
        tick();
        check("ws_addr_c1", 32'(o_imem_addr), 32'd8);
        check("ws_valid_c1", 32'(o_valid),    32'd0);
        tick();
        check("ws_addr_c2", 32'(o_imem_addr), 32'd8);
        check("ws_ready_c2", 32'(i_imem_ready), 32'd1);
        tick();
        check("ws_valid8", 32'(o_valid),     32'd1);
        check("ws_pc8",    32'(o_pc),        32'd8);
        check("ws_addr9",  32'(o_imem_addr), 32'd9);
        tick();
        check("ws_gap1", 32'(o_valid), 32'd0);
        tick();
        check("ws_gap2", 32'(o_valid), 32'd0);
        tick();
        check("ws_valid9", 32'(o_valid), 32'd1);
        check("ws_pc9",    32'(o_pc),    32'd9);

        // redirect to 0x10 mid-wait, then to 0x100 while 0x10 is pending
        i_redirect = 1'b1;
        i_redirect_pc = 14'h0010;
        tick();
        i_redirect = 1'b0;
        check("disc_hold_addr", 32'(o_imem_addr), 32'h000A);
        check("disc_req",       32'(o_imem_req),  32'd1);
        tick();
        tick();
        check("disc_target_addr", 32'(o_imem_addr), 32'h0010);
        i_redirect = 1'b1;
        i_redirect_pc = 14'h0100;
        tick();
        i_redirect = 1'b0;
        check("disc2_hold_addr", 32'(o_imem_addr), 32'h0010);
        for (int k = 0; k < 4; k++) begin
            check("disc2_no_valid", 32'(o_valid), 32'd0);
            tick();
        end
        check("disc2_addr_target", 32'(o_imem_addr), 32'h0100);
        tick();
        check("redir_valid", 32'(o_valid), 32'd1);
        check("redir_pc",    32'(o_pc),    32'h0100);
        check("redir_inst",  32'(o_inst),  32'h14100);

        // redirect to 0x3FFE with zero-wait memory, PC wraps
        wait_states = 0;
        drive_mem();
        i_redirect = 1'b1;
        i_redirect_pc = 14'h3FFE;
        tick();
        i_redirect = 1'b0;
        check("wrap_addr",  32'(o_imem_addr), 32'h3FFE);
        check("wrap_drop",  32'(o_valid),     32'd0);
        tick();
        check("wrap_pc0",     32'(o_pc),     32'h3FFE);
        check("wrap_inst0",   32'(o_inst),   32'h2FFFE);
        check("wrap_opcode0", 32'(o_opcode), 32'hB);
        tick();
        check("wrap_pc1", 32'(o_pc), 32'h3FFF);
        tick();
        check("wrap_pc2",    32'(o_pc),    32'h0000);
        check("wrap_valid2", 32'(o_valid), 32'd1);

        // asynchronous reset in the middle of a wait state
        wait_states = 2;
        drive_mem();
        tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_req",    32'(o_imem_req),  32'd0);
        check("arst_addr",   32'(o_imem_addr), 32'd0);
        check("arst_valid",  32'(o_valid),     32'd0);
        check("arst_inst",   32'(o_inst),      32'd0);
        check("arst_pc",     32'(o_pc),        32'd0);
        check("arst_opcode", 32'(o_opcode),    32'd0);
        tick();
        i_rst_n = 1'b1;
        tick();
        check("rerun_req",  32'(o_imem_req),  32'd1);
        check("rerun_addr", 32'(o_imem_addr), 32'd0);
        tick();
        tick();
        check("rerun_valid_early", 32'(o_valid), 32'd0);
        tick();
        check("rerun_valid", 32'(o_valid), 32'd1);
        check("rerun_pc",    32'(o_pc),    32'd0);
        check("rerun_inst",  32'(o_inst),  32'h14000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
